// File: rtl/f8_alu_pkg.sv
// Shared f8 ALU definitions: instruction encoding and the op classification
// helpers used by the request sequencer.
package f8_alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_ADC   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SBC   = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_PASS  = 5'd8,
    ALU_PASSW = 5'd9,
    ALU_SEX   = 5'd10
  } aluinst_t;

  // High-byte pass chains the low-byte carry, so plain add/sub become carry forms.
  function automatic aluinst_t hi_pass_op(input aluinst_t op);
    case (op)
      ALU_ADD, ALU_ADC: hi_pass_op = ALU_ADC;
      ALU_SUB, ALU_SBC: hi_pass_op = ALU_SBC;
      default:          hi_pass_op = op;
    endcase
  endfunction

  // Ops whose carry propagates from the low byte into the high byte.
  function automatic logic is_carry_op(input aluinst_t op);
    is_carry_op = (op == ALU_ADD) || (op == ALU_ADC) ||
                  (op == ALU_SUB) || (op == ALU_SBC);
  endfunction

  // Ops executed as two byte passes when a wide request is made.
  function automatic logic is_split_op(input aluinst_t op);
    is_split_op = is_carry_op(op) || (op == ALU_AND) ||
                  (op == ALU_OR) || (op == ALU_XOR);
  endfunction

  // Ops the ALU already produces a full 16-bit result for in one pass.
  function automatic logic is_native_wide(input aluinst_t op);
    is_native_wide = (op == ALU_SEX) || (op == ALU_PASSW);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Request-side sequencer for the combinational f8 ALU. Wide add/sub/logic
// ops run as a low-byte pass followed by a carry-chained high-byte pass.
// Optional: define ALU_SEQ_BACK2BACK_EN to accept a new request in the same
// cycle the pending response is consumed.
module alu_seq
  import f8_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  aluinst_t          req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_c,
  input  logic              req_wide,
  output logic [DATA_W-1:0] alu_op0,
  output logic [DATA_W-1:0] alu_op1,
  output aluinst_t          alu_inst,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_z,
  output logic              rsp_n,
  output logic              rsp_c
);

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

  state_t            state_q, state_d;
  aluinst_t          op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              c_q, c_d, split_q, split_d;
  logic [BYTE_W-1:0] lo_res_q, lo_res_d;
  logic              lo_z_q, lo_z_d, lo_c_q, lo_c_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d, rsp_c_q, rsp_c_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] alu_op0_q, alu_op0_d, alu_op1_q, alu_op1_d;
  aluinst_t          alu_inst_q, alu_inst_d;
  logic              alu_c_in_q, alu_c_in_d;
  logic              accept_c, load_req;

  // Request acceptance window.
`ifdef ALU_SEQ_BACK2BACK_EN
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_ready);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif
  assign accept_c = req_valid && req_ready;

  // Next-state, operand latching, ALU drive for the upcoming state, response load.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    split_d      = split_q;
    lo_res_d     = lo_res_q;
    lo_z_d       = lo_z_q;
    lo_c_d       = lo_c_q;
    rsp_result_d = rsp_result_q;
    rsp_z_d      = rsp_z_q;
    rsp_n_d      = rsp_n_q;
    rsp_c_d      = rsp_c_q;
    rsp_valid_d  = rsp_valid_q;
    alu_op0_d    = '0;
    alu_op1_d    = '0;
    alu_inst_d   = ALU_PASS;
    alu_c_in_d   = 1'b0;
    load_req     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) load_req = 1'b1;
      end
      ST_LO: begin
        lo_res_d = alu_result[BYTE_W-1:0];
        lo_z_d   = alu_z;
        lo_c_d   = alu_c;
        if (split_q) begin
          state_d    = ST_HI;
          alu_op0_d  = {{BYTE_W{1'b0}}, a_q[DATA_W-1:BYTE_W]};
          alu_op1_d  = {{BYTE_W{1'b0}}, b_q[DATA_W-1:BYTE_W]};
          alu_inst_d = hi_pass_op(op_q);
          alu_c_in_d = is_carry_op(op_q) ? alu_c : 1'b0;
        end else begin
          state_d      = ST_DONE;
          rsp_valid_d  = 1'b1;
          rsp_result_d = is_native_wide(op_q) ? alu_result
                                              : {{BYTE_W{1'b0}}, alu_result[BYTE_W-1:0]};
          rsp_z_d      = alu_z;
          rsp_n_d      = alu_n;
          rsp_c_d      = alu_c;
        end
      end
      ST_HI: begin
        state_d      = ST_DONE;
        rsp_valid_d  = 1'b1;
        rsp_result_d = {alu_result[BYTE_W-1:0], lo_res_q};
        rsp_z_d      = lo_z_q && alu_z;
        rsp_n_d      = alu_n;
        rsp_c_d      = alu_c;
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
`ifdef ALU_SEQ_BACK2BACK_EN
          if (accept_c) load_req = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_req) begin
      state_d    = ST_LO;
      op_d       = req_op;
      a_d        = req_a;
      b_d        = req_b;
      c_d        = req_c;
      split_d    = req_wide && is_split_op(req_op);
      alu_op0_d  = req_a;
      alu_op1_d  = req_b;
      alu_inst_d = req_op;
      alu_c_in_d = req_c;
    end
  end

  // State and datapath registers; reset aborts any in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= ALU_PASS;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      split_q      <= 1'b0;
      lo_res_q     <= '0;
      lo_z_q       <= 1'b0;
      lo_c_q       <= 1'b0;
      rsp_result_q <= '0;
      rsp_z_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
      rsp_c_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      alu_op0_q    <= '0;
      alu_op1_q    <= '0;
      alu_inst_q   <= ALU_PASS;
      alu_c_in_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      split_q      <= split_d;
      lo_res_q     <= lo_res_d;
      lo_z_q       <= lo_z_d;
      lo_c_q       <= lo_c_d;
      rsp_result_q <= rsp_result_d;
      rsp_z_q      <= rsp_z_d;
      rsp_n_q      <= rsp_n_d;
      rsp_c_q      <= rsp_c_d;
      rsp_valid_q  <= rsp_valid_d;
      alu_op0_q    <= alu_op0_d;
      alu_op1_q    <= alu_op1_d;
      alu_inst_q   <= alu_inst_d;
      alu_c_in_q   <= alu_c_in_d;
    end
  end

  assign alu_op0    = alu_op0_q;
  assign alu_op1    = alu_op1_q;
  assign alu_inst   = alu_inst_q;
  assign alu_c_in   = alu_c_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_n      = rsp_n_q;
  assign rsp_c      = rsp_c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a byte-wide ALU model attached and a
// 16-bit arithmetic reference for expected responses.
module tb_alu_seq;
  import f8_alu_pkg::*;

  logic        clk, reset_n;
  logic        req_valid, req_ready, req_c, req_wide;
  aluinst_t    req_op;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_op0, alu_op1, alu_result;
  aluinst_t    alu_inst;
  logic        alu_c_in, alu_z, alu_n, alu_c;
  logic        rsp_valid, rsp_ready, rsp_z, rsp_n, rsp_c;
  logic [15:0] rsp_result;

  int errors = 0;
  int checks = 0;

  alu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_wide(req_wide),
    .alu_op0(alu_op0), .alu_op1(alu_op1), .alu_inst(alu_inst), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_c(rsp_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: byte ops with carry out; SEX/PASSW produce 16 bits.
  logic [8:0] s9;
  always_comb begin
    s9 = '0;
    case (alu_inst)
      ALU_ADD: s9 = {1'b0, alu_op0[7:0]} + {1'b0, alu_op1[7:0]};
      ALU_ADC: s9 = {1'b0, alu_op0[7:0]} + {1'b0, alu_op1[7:0]} + {8'h00, alu_c_in};
      ALU_SUB: s9 = {1'b0, alu_op0[7:0]} + {1'b0, ~alu_op1[7:0]} + 9'd1;
      ALU_SBC: s9 = {1'b0, alu_op0[7:0]} + {1'b0, ~alu_op1[7:0]} + {8'h00, alu_c_in};
      ALU_AND: s9 = {1'b0, alu_op0[7:0] & alu_op1[7:0]};
      ALU_OR:  s9 = {1'b0, alu_op0[7:0] | alu_op1[7:0]};
      ALU_XOR: s9 = {1'b0, alu_op0[7:0] ^ alu_op1[7:0]};
      ALU_SRL: s9 = {alu_op0[0], 1'b0, alu_op0[7:1]};
      ALU_PASS: s9 = {1'b0, alu_op0[7:0]};
      default: s9 = '0;
    endcase
    alu_result = {8'h00, s9[7:0]};
    alu_c      = s9[8];
    alu_z      = (s9[7:0] == 8'h00);
    alu_n      = s9[7];
    if (alu_inst == ALU_SEX || alu_inst == ALU_PASSW) begin
      alu_result = (alu_inst == ALU_SEX) ? {{8{alu_op0[7]}}, alu_op0[7:0]} : alu_op0;
      alu_c      = 1'b0;
      alu_z      = (alu_result == 16'h0000);
      alu_n      = alu_result[15];
    end
  end

  // Expected response computed with whole-word arithmetic.
  function automatic void ref_model(input aluinst_t op, input logic [15:0] a, b,
                                    input logic ci, w, output logic [15:0] res,
                                    output logic z, n, co, output int lat);
    logic split, wide_res, arith;
    logic [15:0] bb;
    logic [16:0] s;
    split    = w && (op inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR, ALU_XOR});
    wide_res = split || op == ALU_SEX || op == ALU_PASSW;
    arith    = op inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC};
    bb = (op == ALU_SUB || op == ALU_SBC) ? ~b : b;
    if (!wide_res) begin
      bb = {8'h00, bb[7:0]};
    end
    co = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: s = {1'b0, wide_res ? a : {8'h00, a[7:0]}} + {1'b0, bb}
                            + ((op == ALU_ADC) ? {16'h0, ci} : 17'd0);
      ALU_SUB, ALU_SBC: s = {1'b0, wide_res ? a : {8'h00, a[7:0]}} + {1'b0, bb}
                            + ((op == ALU_SUB) ? 17'd1 : {16'h0, ci});
      ALU_AND:   s = {1'b0, a & b};
      ALU_OR:    s = {1'b0, a | b};
      ALU_XOR:   s = {1'b0, a ^ b};
      ALU_SRL:   begin s = {9'h000, a[7:0]} >> 1; co = a[0]; end
      ALU_SEX:   s = {1'b0, {8{a[7]}}, a[7:0]};
      default:   s = {1'b0, a};
    endcase
    if (wide_res) begin
      res = s[15:0];
      if (arith) co = s[16];
      n = res[15];
    end else begin
      res = {8'h00, s[7:0]};
      if (arith) co = s[8];
      n = res[7];
    end
    z   = (res == 16'h0000);
    lat = split ? 3 : 2;
  endfunction

  // Issue one request, observe ALU drive per pass, collect the response.
  task automatic run_op(input aluinst_t op, input logic [15:0] a, b, input logic ci, w,
                        output logic [15:0] res, output logic z, n, co, output int lat,
                        output aluinst_t i_lo, i_hi, output logic cin_hi,
                        output logic [15:0] op0_hi);
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = ci; req_wide = w;
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom);
    req_c = 1'($urandom); req_wide = 1'($urandom);
    lat = -1; i_lo = ALU_PASS; i_hi = ALU_PASS; cin_hi = 1'b0; op0_hi = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) i_lo = alu_inst;
      if (c == 2) begin i_hi = alu_inst; cin_hi = alu_c_in; op0_hi = alu_op0; end
      if (rsp_valid) begin lat = c; break; end
      @(negedge clk);
    end
    res = rsp_result; z = rsp_z; n = rsp_n; co = rsp_c;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_result, rsp_z, rsp_n, rsp_c} !== 19'h0) begin errors++;
      $display("FAIL reset_rsp got=%h %b%b%b exp=0000 000", rsp_result, rsp_z, rsp_n, rsp_c); end
    checks++; if (alu_inst !== ALU_PASS || alu_op0 !== 16'h0 || alu_op1 !== 16'h0 || alu_c_in !== 1'b0) begin
      errors++; $display("FAIL reset_alu_drive got=%0d %h %h %b", alu_inst, alu_op0, alu_op1, alu_c_in); end
  endtask

  task automatic test_directed();
    logic [15:0] r, o0; logic z, n, c, ch; int lat; aluinst_t il, ih;
    run_op(ALU_ADD, 16'h00F0, 16'h0020, 1'b0, 1'b0, r, z, n, c, lat, il, ih, ch, o0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL narrow_add_lat got=%0d exp=2", lat); end
    checks++; if (r !== 16'h0010 || c !== 1'b1) begin errors++; $display("FAIL narrow_add got=%h c=%b exp=0010 c=1", r, c); end
    checks++; if (il !== ALU_ADD) begin errors++; $display("FAIL narrow_add_inst got=%0d exp=%0d", il, ALU_ADD); end
    run_op(ALU_ADD, 16'h12F0, 16'h0120, 1'b0, 1'b1, r, z, n, c, lat, il, ih, ch, o0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wide_add_lat got=%0d exp=3", lat); end
    checks++; if (r !== 16'h1410 || c !== 1'b0) begin errors++; $display("FAIL wide_add got=%h c=%b exp=1410 c=0", r, c); end
    checks++; if (il !== ALU_ADD || ih !== ALU_ADC || ch !== 1'b1) begin errors++;
      $display("FAIL wide_add_passes got=%0d/%0d cin=%b exp=%0d/%0d cin=1", il, ih, ch, ALU_ADD, ALU_ADC); end
    run_op(ALU_SUB, 16'h1000, 16'h0001, 1'b0, 1'b1, r, z, n, c, lat, il, ih, ch, o0);
    checks++; if (r !== 16'h0FFF) begin errors++; $display("FAIL wide_sub got=%h exp=0fff", r); end
    checks++; if (ih !== ALU_SBC || ch !== 1'b0) begin errors++;
      $display("FAIL wide_sub_hi got=%0d cin=%b exp=%0d cin=0", ih, ch, ALU_SBC); end
    run_op(ALU_SEX, 16'h0080, 16'h0000, 1'b0, 1'b1, r, z, n, c, lat, il, ih, ch, o0);
    checks++; if (lat !== 2 || r !== 16'hFF80 || n !== 1'b1) begin errors++;
      $display("FAIL sex got lat=%0d r=%h n=%b exp lat=2 r=ff80 n=1", lat, r, n); end
  endtask

  task automatic test_hold();
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_ADD; req_a = 16'h00F0; req_b = 16'h0020; req_c = 1'b0; req_wide = 1'b0;
    @(negedge clk);
    req_op = ALU_XOR; req_a = 16'h5555; req_b = 16'h0F0F;
    k = 0;
    while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h0010 || rsp_c !== 1'b1 || rsp_z !== 1'b0) begin
        errors++; $display("FAIL hold_rsp cyc=%0d got v=%b r=%h c=%b z=%b exp v=1 r=0010 c=1 z=0",
                           i, rsp_valid, rsp_result, rsp_c, rsp_z); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
        $display("FAIL hold_release cyc=%0d got v=%b rdy=%b exp v=0 rdy=1", i, rsp_valid, req_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_ADD; req_a = 16'h12F0; req_b = 16'h0120; req_c = 1'b0; req_wide = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (alu_inst !== ALU_ADC) begin errors++; $display("FAIL abort_in_hi got=%0d exp=%0d", alu_inst, ALU_ADC); end
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== 16'h0000) begin errors++;
      $display("FAIL abort_reset got v=%b rdy=%b r=%h exp v=0 rdy=1 r=0000", rsp_valid, req_ready, rsp_result); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
        $display("FAIL abort_no_rsp cyc=%0d got v=%b rdy=%b exp v=0 rdy=1", i, rsp_valid, req_ready); end
    end
  endtask

  task automatic test_random();
    aluinst_t ops [11] = '{ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR,
                           ALU_XOR, ALU_SRL, ALU_PASS, ALU_PASSW, ALU_SEX};
    aluinst_t op, il, ih, eih;
    logic [15:0] a, b, r, er, er_lo, o0;
    logic ci, w, z, n, c, ez, en, ec, dz, dn, lo_c, ch;
    int lat, elat, dlat;
    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(0, 10)];
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); w = 1'($urandom);
      if (t % 8 == 0) b = a;
      ref_model(op, a, b, ci, w, er, ez, en, ec, elat);
      ref_model(op, a, b, ci, 1'b0, er_lo, dz, dn, lo_c, dlat);
      run_op(op, a, b, ci, w, r, z, n, c, lat, il, ih, ch, o0);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_lat t=%0d op=%0d got=%0d exp=%0d", t, op, lat, elat); end
      checks++; if ({r, z, n, c} !== {er, ez, en, ec}) begin errors++;
        $display("FAIL rnd_rsp t=%0d op=%0d a=%h b=%h ci=%b w=%b got=%h %b%b%b exp=%h %b%b%b",
                 t, op, a, b, ci, w, r, z, n, c, er, ez, en, ec); end
      checks++; if (il !== op) begin errors++; $display("FAIL rnd_lo_inst t=%0d got=%0d exp=%0d", t, il, op); end
      if (elat == 3) begin
        case (op)
          ALU_ADD, ALU_ADC: eih = ALU_ADC;
          ALU_SUB, ALU_SBC: eih = ALU_SBC;
          default:          eih = op;
        endcase
        checks++; if (ih !== eih || ch !== lo_c || o0 !== {8'h00, a[15:8]}) begin errors++;
          $display("FAIL rnd_hi t=%0d got=%0d cin=%b op0=%h exp=%0d cin=%b op0=%h",
                   t, ih, ch, o0, eih, lo_c, {8'h00, a[15:8]}); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = ALU_PASS; req_a = '0; req_b = '0;
    req_c = 1'b0; req_wide = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
